// File: rtl/gpio_in_debouncer.sv
// Per-bit synchroniser and debouncer for raw GPIO pads, with change pulses.
// Optional sticky IRQ flags and IRQ line when GPIO_IN_IRQ_EN is defined.
module gpio_in_debouncer #(
    parameter int BITS_PORT       = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BITS_PORT-1:0] pin_in,
    output logic [BITS_PORT-1:0] data_out,
    output logic [BITS_PORT-1:0] change_pulse,
    input  logic [BITS_PORT-1:0] irq_mask,
    input  logic [BITS_PORT-1:0] irq_clear,
    output logic [BITS_PORT-1:0] irq_flags,
    output logic                 irq_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BITS_PORT-1:0] sync_q [SYNC_STAGES];
    logic [BITS_PORT-1:0] sync_s;
    logic [CNT_W-1:0]     cnt_q  [BITS_PORT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A bit commits only after its new level has been seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out     <= '0;
            change_pulse <= '0;
            for (int unsigned i = 0; i < BITS_PORT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            change_pulse <= '0;
            for (int unsigned i = 0; i < BITS_PORT; i++) begin
                if (sync_s[i] != data_out[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        data_out[i]     <= sync_s[i];
                        change_pulse[i] <= 1'b1;
                        cnt_q[i]        <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

`ifdef GPIO_IN_IRQ_EN
    // Set has priority over a coincident write-1-to-clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_flags <= '0;
        end else begin
            irq_flags <= (irq_flags & ~irq_clear) | (change_pulse & irq_mask);
        end
    end

    assign irq_out = |irq_flags;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_mask, irq_clear};
    assign irq_flags         = '0;
    assign irq_out           = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_debouncer.sv
// Randomised and directed bench for gpio_in_debouncer against a sliding-window model.
// Honours GPIO_IN_IRQ_EN the same way as the design.
module tb_gpio_in_debouncer;

    localparam int BITS = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [BITS-1:0] pin_in;
    logic [BITS-1:0] data_out;
    logic [BITS-1:0] change_pulse;
    logic [BITS-1:0] irq_mask;
    logic [BITS-1:0] irq_clear;
    logic [BITS-1:0] irq_flags;
    logic            irq_out;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_debouncer #(
        .BITS_PORT       (BITS),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .pin_in       (pin_in),
        .data_out     (data_out),
        .change_pulse (change_pulse),
        .irq_mask     (irq_mask),
        .irq_clear    (irq_clear),
        .irq_flags    (irq_flags),
        .irq_out      (irq_out)
    );

    always #5 CLK = ~CLK;

    // Reference state: a delay line for the synchroniser and a window of the last DEB
    // synchronised samples; a bit flips when every sample in a full window disagrees.
    logic [BITS-1:0] m_pipe [SYNC];
    logic [BITS-1:0] s_win  [$];
    logic [BITS-1:0] m_dout  = '0;
    logic [BITS-1:0] m_pulse = '0;
    logic [BITS-1:0] m_flags = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_clk();
        logic [BITS-1:0] s_e;
        logic [BITS-1:0] new_pulse;
        logic            all_diff;
        @(posedge CLK);
        if (RST) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
            s_win.delete();
            m_dout  = '0;
            m_pulse = '0;
            m_flags = '0;
        end else begin
            s_e = m_pipe[SYNC-1];
`ifdef GPIO_IN_IRQ_EN
            m_flags = (m_flags & ~irq_clear) | (m_pulse & irq_mask);
`endif
            s_win.push_back(s_e);
            if (s_win.size() > DEB) void'(s_win.pop_front());
            new_pulse = '0;
            if (s_win.size() == DEB) begin
                for (int i = 0; i < BITS; i++) begin
                    all_diff = 1'b1;
                    foreach (s_win[j]) if (s_win[j][i] == m_dout[i]) all_diff = 1'b0;
                    new_pulse[i] = all_diff;
                end
            end
            m_dout  = m_dout ^ new_pulse;
            m_pulse = new_pulse;
            for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = pin_in;
        end
        @(negedge CLK);
        check("data_out", data_out, m_dout);
        check("change_pulse", change_pulse, m_pulse);
        check("irq_flags", irq_flags, m_flags);
        check("irq_out", irq_out, |m_flags);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step_clk();
    endtask

    initial begin
        for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
        RST       = 1'b1;
        pin_in    = 8'hFF;
        irq_mask  = '0;
        irq_clear = '0;

        // Reset with all pins high, then release.
        run(2);
        check("rst_data", data_out, 8'h00);
        check("rst_pulse", change_pulse, 8'h00);
        check("rst_irq", irq_out, 1'b0);
        RST = 1'b0;
        run(17);
        check("t1_edge17", data_out, 8'h00);
        run(1);
        check("t1_edge18_data", data_out, 8'hFF);
        check("t1_edge18_pulse", change_pulse, 8'hFF);
        run(1);
        check("t1_pulse_1cyc", change_pulse, 8'h00);

        // Single rising bit, exact latency.
        pin_in = 8'h00;
        run(DEB + SYNC + 4);
        check("t2_settled", data_out, 8'h00);
        pin_in = 8'h01;
        run(17);
        check("t2_edge17", data_out, 8'h00);
        run(1);
        check("t2_edge18", data_out, 8'h01);
        check("t2_pulse", change_pulse, 8'h01);

        // Short glitch is rejected.
        pin_in = 8'h00;
        run(DEB + SYNC + 4);
        pin_in = 8'h08;
        run(10);
        pin_in = 8'h00;
        run(DEB + SYNC + 4);
        check("t3_glitch", data_out, 8'h00);

        // Two bits change together.
        pin_in = 8'h81;
        run(18);
        check("t4_data", data_out, 8'h81);
        check("t4_pulse", change_pulse, 8'h81);
        pin_in = 8'h00;
        run(DEB + SYNC + 4);

`ifdef GPIO_IN_IRQ_EN
        irq_mask = 8'h01;
        pin_in   = 8'h03;
        run(19);
        check("t5_flags", irq_flags, 8'h01);
        check("t5_irq", irq_out, 1'b1);
        irq_clear = 8'h01;
        run(1);
        irq_clear = 8'h00;
        check("t5_cleared", irq_flags, 8'h00);
        pin_in = 8'h02;
        run(18);
        irq_clear = 8'h01;
        run(1);
        irq_clear = 8'h00;
        check("t5_set_wins", irq_flags, 8'h01);
        irq_clear = 8'hFF;
        run(1);
        irq_clear = 8'h00;
        irq_mask  = 8'h00;
        pin_in    = 8'h00;
        run(DEB + SYNC + 4);
`endif

        // Reset during a pending change on bit 2.
        pin_in = 8'h04;
        run(12);
        RST = 1'b1;
        run(1);
        check("t6_rst_data", data_out, 8'h00);
        RST = 1'b0;
        run(17);
        check("t6_edge17", data_out, 8'h00);
        run(1);
        check("t6_edge18", data_out, 8'h04);
        check("t6_pulse", change_pulse, 8'h04);

        // Random phase: sparse pin flips, random mask/clear, rare resets.
        for (int c = 0; c < 1500; c++) begin
            logic [BITS-1:0] flip;
            flip = '0;
            for (int i = 0; i < BITS; i++) flip[i] = ($urandom_range(0, 23) == 0);
            pin_in    = pin_in ^ flip;
            irq_mask  = BITS'($urandom);
            irq_clear = BITS'($urandom & $urandom);
            RST       = ($urandom_range(0, 299) == 0);
            step_clk();
        end
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
